// File: rtl/uart_alu_top_pkg.sv
// uart_alu_top_pkg: default parameters, opcodes and FSM encodings shared by the serial ALU.
package uart_alu_top_pkg;
    localparam int DEF_LIMITE   = 163;
    localparam int DEF_NB_CONTA = 8;
    localparam int DEF_N_BITS   = 8;
    localparam int DEF_N_TICKS  = 16;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_ADD = 6'b100000;
    localparam opcode_t OP_SUB = 6'b100010;
    localparam opcode_t OP_AND = 6'b100100;
    localparam opcode_t OP_OR  = 6'b100101;
    localparam opcode_t OP_XOR = 6'b100110;
    localparam opcode_t OP_SRA = 6'b000011;
    localparam opcode_t OP_SRL = 6'b000010;
    localparam opcode_t OP_NOR = 6'b100111;

    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

    localparam logic [2:0] IF_WAIT_A  = 3'd0;
    localparam logic [2:0] IF_WAIT_B  = 3'd1;
    localparam logic [2:0] IF_WAIT_OP = 3'd2;
    localparam logic [2:0] IF_SEND    = 3'd3;
    localparam logic [2:0] IF_WAIT_TX = 3'd4;
endpackage

// File: rtl/uart_alu_top_uart.sv
// uart_alu_top_uart: oversampling baud tick shared by an 8N1 receiver and a registered 8N1 transmitter.
module uart_alu_top_uart
    import uart_alu_top_pkg::*;
#(
    parameter int LIMITE   = DEF_LIMITE,
    parameter int NB_CONTA = DEF_NB_CONTA,
    parameter int N_BITS   = DEF_N_BITS,
    parameter int N_TICKS  = DEF_N_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              rx_done,
    output logic [N_BITS-1:0] rx_data,
    input  logic              tx_start,
    input  logic [N_BITS-1:0] tx_data,
    output logic              tx,
    output logic              tx_done
);
    localparam int SW = $clog2(N_TICKS);
    localparam int NW = $clog2(N_BITS);
    localparam logic [NB_CONTA-1:0] CNT_LAST = NB_CONTA'(LIMITE - 1);
    localparam logic [SW-1:0] S_MID  = SW'(N_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(N_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_BITS - 1);

    logic [NB_CONTA-1:0] cnt;
    logic                tick;
    logic [1:0]          rx_sync;
    logic                rx_s;
    logic [1:0]          rx_state;
    logic [SW-1:0]       rx_cnt;
    logic [NW-1:0]       rx_n;
    logic [1:0]          tx_state;
    logic [SW-1:0]       tx_cnt;
    logic [NW-1:0]       tx_n;
    logic [N_BITS-1:0]   tx_buf;
    logic                tx_bit_end;

    assign tick       = cnt == CNT_LAST;
    assign rx_s       = rx_sync[1];
    assign tx_bit_end = tick && tx_cnt == S_LAST;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + NB_CONTA'(1);

    // The line is asynchronous to clk, so it is double-registered before any decision.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= UART_IDLE;
            rx_cnt   <= '0;
            rx_n     <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                UART_IDLE: if (!rx_s) begin
                    rx_state <= UART_START;
                    rx_cnt   <= '0;
                end
                UART_START: if (tick) begin
                    if (rx_cnt == S_MID) begin
                        rx_state <= rx_s ? UART_IDLE : UART_DATA;
                        rx_cnt   <= '0;
                        rx_n     <= '0;
                    end else rx_cnt <= rx_cnt + SW'(1);
                end
                UART_DATA: if (tick) begin
                    if (rx_cnt == S_LAST) begin
                        rx_cnt  <= '0;
                        rx_data <= {rx_s, rx_data[N_BITS-1:1]};
                        rx_n    <= rx_n + NW'(1);
                        if (rx_n == N_LAST) rx_state <= UART_STOP;
                    end else rx_cnt <= rx_cnt + SW'(1);
                end
                default: if (tick) begin
                    if (rx_cnt == S_LAST) begin
                        rx_state <= UART_IDLE;
                        rx_done  <= 1'b1;
                    end else rx_cnt <= rx_cnt + SW'(1);
                end
            endcase
        end
    end

    // tx is updated on the same edge as the state change so the line never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= UART_IDLE;
            tx_cnt   <= '0;
            tx_n     <= '0;
            tx_buf   <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tick && tx_state != UART_IDLE) tx_cnt <= tx_bit_end ? '0 : tx_cnt + SW'(1);
            case (tx_state)
                UART_IDLE: if (tx_start) begin
                    tx_state <= UART_START;
                    tx_buf   <= tx_data;
                    tx_cnt   <= '0;
                    tx       <= 1'b0;
                end
                UART_START: if (tx_bit_end) begin
                    tx_state <= UART_DATA;
                    tx_n     <= '0;
                    tx       <= tx_buf[0];
                end
                UART_DATA: if (tx_bit_end) begin
                    tx_buf <= tx_buf >> 1;
                    tx_n   <= tx_n + NW'(1);
                    tx     <= tx_n == N_LAST ? 1'b1 : tx_buf[1];
                    if (tx_n == N_LAST) tx_state <= UART_STOP;
                end
                default: if (tx_bit_end) begin
                    tx_state <= UART_IDLE;
                    tx_done  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_alu_top.sv
// uart_alu_top: serial ALU taking A, B and an opcode as three UART bytes and returning the result byte.
module uart_alu_top
    import uart_alu_top_pkg::*;
#(
    parameter int LIMITE   = DEF_LIMITE,
    parameter int NB_CONTA = DEF_NB_CONTA,
    parameter int N_BITS   = DEF_N_BITS,
    parameter int N_TICKS  = DEF_N_TICKS
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_rx,
    output logic o_tx,
    output logic o_tx_done_tick
);
    logic                     rx_done;
    logic [N_BITS-1:0]        rx_data;
    logic [N_BITS-1:0]        a;
    logic [N_BITS-1:0]        b;
    logic [N_BITS-1:0]        result;
    logic signed [N_BITS-1:0] sra;
    opcode_t                  op;
    logic [2:0]               state;

    uart_alu_top_uart #(
        .LIMITE  (LIMITE),
        .NB_CONTA(NB_CONTA),
        .N_BITS  (N_BITS),
        .N_TICKS (N_TICKS)
    ) u_uart (
        .clk     (i_clock),
        .rst_n   (i_reset),
        .rx      (i_rx),
        .rx_done (rx_done),
        .rx_data (rx_data),
        .tx_start(state == IF_SEND),
        .tx_data (result),
        .tx      (o_tx),
        .tx_done (o_tx_done_tick)
    );

    // Kept apart so the arithmetic shift is not turned logical by the unsigned select below.
    assign sra = $signed(a) >>> b;

    assign result = op == OP_ADD ? a + b :
                    op == OP_SUB ? a - b :
                    op == OP_AND ? a & b :
                    op == OP_OR  ? a | b :
                    op == OP_XOR ? a ^ b :
                    op == OP_SRA ? sra :
                    op == OP_SRL ? a >> b :
                    op == OP_NOR ? ~(a | b) : '0;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IF_WAIT_A;
            a     <= '0;
            b     <= '0;
            op    <= '0;
        end else begin
            case (state)
                IF_WAIT_A: if (rx_done) begin
                    a     <= rx_data;
                    state <= IF_WAIT_B;
                end
                IF_WAIT_B: if (rx_done) begin
                    b     <= rx_data;
                    state <= IF_WAIT_OP;
                end
                IF_WAIT_OP: if (rx_done) begin
                    op    <= rx_data[5:0];
                    state <= IF_SEND;
                end
                IF_SEND:    state <= IF_WAIT_TX;
                IF_WAIT_TX: if (o_tx_done_tick) state <= IF_WAIT_A;
                default:    state <= IF_WAIT_A;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_alu_top.sv
`timescale 1ns/1ps
// tb_uart_alu_top: directed serial ALU sequences; expected result bytes are queued and checked as TX frames arrive.
module tb_uart_alu_top;
    localparam int LIMITE = 2;
    localparam int BIT    = LIMITE * 16;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    logic i_rx    = 1'b1;
    logic o_tx;
    logic o_tx_done_tick;

    int passes   = 0;
    int fails    = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    logic mon_on        = 1'b0;
    logic frame_active  = 1'b0;
    logic abort_pending = 1'b0;

    uart_alu_top #(
        .LIMITE  (LIMITE),
        .NB_CONTA(8),
        .N_BITS  (8),
        .N_TICKS (16)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_rx          (i_rx),
        .o_tx          (o_tx),
        .o_tx_done_tick(o_tx_done_tick)
    );

    always #10 i_clock = ~i_clock;

    always @(posedge i_clock) if (o_tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(negedge i_clock) i_rx = 1'b0;
        repeat (BIT) @(negedge i_clock);
        for (int k = 0; k < 8; k++) begin
            i_rx = v[k];
            repeat (BIT) @(negedge i_clock);
        end
        i_rx = 1'b1;
        repeat (2 * BIT) @(negedge i_clock);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || frame_active) && n < 16 * BIT) begin
            @(negedge i_clock);
            n++;
        end
        check(tag, 8'(n < 16 * BIT), 8'd1);
        if (n >= 16 * BIT) exp_q.delete();
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [7:0] expv);
        exp_q.push_back(expv);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_idle("seq_complete");
    endtask

    // TX monitor: samples each frame mid-bit and pops the scoreboard.
    initial begin
        logic [7:0] got;
        logic start_bit;
        logic stop_bit;
        int d0;
        int d_mid;
        wait (mon_on);
        forever begin
            @(negedge o_tx);
            frame_active = 1'b1;
            d0 = done_cnt;
            repeat (BIT / 2) @(negedge i_clock);
            start_bit = o_tx;
            repeat (BIT - 1) @(negedge i_clock);
            for (int k = 0; k < 8; k++) begin
                got[k] = o_tx;
                repeat (BIT) @(negedge i_clock);
            end
            stop_bit = o_tx;
            d_mid = done_cnt;
            for (int n = 0; n < 2 * BIT && done_cnt == d0; n++) @(negedge i_clock);
            repeat (4) @(negedge i_clock);
            if (abort_pending) begin
                abort_pending = 1'b0;
                check("abort_no_done", 8'(done_cnt - d0), 8'd0);
            end else begin
                check("frame_expected", 8'(exp_q.size() != 0), 8'd1);
                if (exp_q.size() != 0) begin
                    check("tx_byte", got, exp_q.pop_front());
                    check("start_bit", 8'(start_bit), 8'd0);
                    check("stop_bit", 8'(stop_bit), 8'd1);
                    check("done_not_before_stop_end", 8'(d_mid - d0), 8'd0);
                    check("done_pulse_once", 8'(done_cnt - d0), 8'd1);
                end
            end
            frame_active = 1'b0;
        end
    end

    initial begin
        int n;
        int d;
        #5 i_reset = 1'b0;
        #1;
        check("reset_tx", 8'(o_tx), 8'd1);
        check("reset_done", 8'(o_tx_done_tick), 8'd0);
        #79 i_reset = 1'b1;
        mon_on = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (BIT) @(negedge i_clock);
            check("idle_tx", 8'(o_tx), 8'd1);
            check("idle_done", 8'(o_tx_done_tick), 8'd0);
        end
        check("idle_no_frame", 8'(frame_active), 8'd0);

        run(8'h55, 8'h57, 8'h24, 8'h55);
        run(8'h55, 8'h57, 8'h20, 8'hAC);
        run(8'h55, 8'h57, 8'h22, 8'hFE);
        run(8'h55, 8'h57, 8'h27, 8'hA8);
        run(8'h55, 8'h57, 8'h25, 8'h57);
        run(8'h55, 8'h57, 8'h26, 8'h02);
        run(8'h80, 8'h02, 8'h03, 8'hE0);
        run(8'h80, 8'h02, 8'h02, 8'h20);
        run(8'h80, 8'h57, 8'h03, 8'hFF);
        run(8'h80, 8'h08, 8'h02, 8'h00);
        run(8'h40, 8'h08, 8'h03, 8'h00);
        run(8'h55, 8'h57, 8'h3F, 8'h00);
        run(8'h55, 8'h57, 8'hE4, 8'h55);
        run(8'h55, 8'h57, 8'h24, 8'h55);
        run(8'h55, 8'h57, 8'h24, 8'h55);

        // Short low pulse must be rejected as a glitch and leave the byte sequence untouched.
        d = done_cnt;
        @(negedge i_clock) i_rx = 1'b0;
        repeat (6) @(negedge i_clock);
        i_rx = 1'b1;
        repeat (2 * BIT) @(negedge i_clock);
        check("glitch_no_frame", 8'(frame_active), 8'd0);
        check("glitch_no_done", 8'(done_cnt - d), 8'd0);
        run(8'h55, 8'h57, 8'h24, 8'h55);

        // Reset during data bit 1 of a 0x55 frame, where the line is low.
        abort_pending = 1'b1;
        send_byte(8'h55);
        send_byte(8'h57);
        send_byte(8'h24);
        check("abort_frame_started", 8'(frame_active), 8'd1);
        repeat (BIT) @(negedge i_clock);
        check("pre_reset_tx_bit1", 8'(o_tx), 8'd0);
        i_reset = 1'b0;
        #1;
        check("mid_tx_reset_tx", 8'(o_tx), 8'd1);
        check("mid_tx_reset_done", 8'(o_tx_done_tick), 8'd0);
        repeat (4) @(negedge i_clock);
        i_reset = 1'b1;
        repeat (BIT) @(negedge i_clock);
        check("post_reset_tx", 8'(o_tx), 8'd1);
        n = 0;
        while (frame_active && n < 16 * BIT) begin
            @(negedge i_clock);
            n++;
        end
        check("abort_monitor_idle", 8'(n < 16 * BIT), 8'd1);
        run(8'h55, 8'h57, 8'h20, 8'hAC);

        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end
endmodule

// File: doc/uart_alu_top.md
Name: uart_alu_top

Overview:
Integrated serial ALU for a 50 MHz board: receives operand A, operand B and an opcode as three 8N1 UART bytes at 19200 baud. It computes the ALU result and transmits it back as one 8N1 byte. Contains a baud tick generator, UART RX, an interface FSM, a combinational ALU and UART TX. It is the top-level of the design.

Parameters:
LIMITE, 163, baud counter terminal count (clocks per oversample tick; 50e6/(19200*16))
NB_CONTA, 8, width of baud counter
N_BITS, 8, data bits per UART frame and ALU operand/result width
N_TICKS, 16, oversample ticks per bit

Ports:
i_clock  in  1  system clock, 50 MHz, all logic on rising edge
i_reset  in  1  asynchronous, active-low reset
i_rx  in  1  UART receive line, idle high
o_tx  out  1  UART transmit line, idle high
o_tx_done_tick  out  1  one-clock pulse when a TX frame (stop bit) completes

Behaviour:
- Clocking/reset: one clock (i_clock). i_reset is asynchronous and active-low. During reset, all FSMs return to idle, the baud counter is cleared, o_tx=1 and o_tx_done_tick=0. Reset mid-frame aborts that frame; no partial byte is used.
- Baud gen: counter runs 0..LIMITE-1 and wraps. Tick is a 1-clock pulse when count==LIMITE-1, i.e. one tick every 163 clocks. One bit lasts N_TICKS ticks = 2608 clocks = 52160 ns.
- RX FSM states IDLE, START, DATA, STOP:
  - IDLE: waits for i_rx=0.
  - START: counts 7 ticks (mid-bit). If i_rx is still 0, go to DATA; otherwise it was a glitch and the FSM returns to IDLE.
  - DATA: samples every 16 ticks, LSB first, N_BITS bits.
  - STOP: waits 16 ticks, then emits rx_done (1 clock) with the byte and returns to IDLE.
  - No framing check: the byte is delivered even if the stop bit is sampled low.
- Interface FSM states WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX:
  - Each rx_done latches, in order, A, then B, then opcode (low 6 bits; upper 2 ignored).
  - After the opcode, SEND issues a 1-clock tx_start carrying the ALU result, the clock after the opcode rx_done.
  - WAIT_TX holds until tx_done, then returns to WAIT_A.
  - rx_done pulses arriving in SEND/WAIT_TX are discarded.
- ALU: combinational on registered A, B, OP. Operands are signed N_BITS; the result is truncated to N_BITS.
  - ADD 100000: A+B
  - SUB 100010: A-B
  - AND 100100: A&B
  - OR 100101: A|B
  - XOR 100110: A^B
  - SRA 000011: A>>>B, arithmetic with sign fill
  - SRL 000010: A>>B, zero fill
  - NOR 100111: ~(A|B)
  - Any other opcode: 0.
  - Shift amount is the full B. A shift ≥N_BITS gives all sign bits (SRA) or 0 (SRL).
- TX FSM states IDLE, START, DATA, STOP:
  - tx_start in IDLE loads the byte. o_tx drives 0 for 16 ticks, then data LSB first for 16 ticks each, then 1 for 16 ticks.
  - o_tx_done_tick pulses 1 clock at the end of the stop bit, then TX returns to IDLE.
  - tx_start while busy is ignored.
  - o_tx is registered (glitch-free).

Decomposition:
- Shared package: opcode constants (ADD, SUB, AND, OR, XOR, SRA, SRL, NOR), default N_BITS/N_TICKS/LIMITE/NB_CONTA, FSM state encodings.
- Natural sub-modules: baud_gen, uart_rx, uart_tx (sharing the baud tick), alu, uart_alu_if.

Test Plan:
- Reset held 80 ns then released, no RX traffic -> o_tx=1, o_tx_done_tick=0 indefinitely.
- Send A=0x55, B=0x57, op=0x24 (AND), 52160 ns/bit, ≥90000 ns gaps -> TX frame carries 0x55, LSB first; o_tx_done_tick pulses once at the end of the stop bit.
- Same A/B with ADD, SUB, NOR -> 0xAC, 0xFE, 0xA8 respectively.
- A=0x80, B=0x02: SRA -> 0xE0; SRL -> 0x20. A=0x80, B=0x57, SRA -> 0xFF.
- Opcode 0x3F (undefined) -> result 0x00 transmitted. Two back-to-back A/B/AND sequences -> two correct 0x55 frames (FSM wraps).
- 2000 ns low pulse on i_rx -> no byte accepted and FSM remains in WAIT_A. Reset asserted mid-TX -> o_tx returns high immediately, and the next full sequence works.
